// File: rtl/lane_response_checker_if.sv
// Stimulus/response bus between the lane driver and the response checker.
interface lane_response_checker_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             stim_valid;
  logic [WIDTH-1:0] stim_data;
  logic             stim_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;

  // Driver side: presents stimulus and returned responses.
  modport master (
    output stim_valid,
    output stim_data,
    output resp_valid,
    output resp_data,
    input  stim_ready
  );

  // Checker side.
  modport slave (
    input  stim_valid,
    input  stim_data,
    input  resp_valid,
    input  resp_data,
    output stim_ready
  );

endinterface

// File: rtl/lane_response_checker.sv
// Logs stimulus vectors into an expected-value FIFO and checks returned lane responses in
// order, keeping sticky per-lane error flags, a saturating error count and a pass verdict.
module lane_response_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INVERT  = 0,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 stop_i,
  lane_response_checker_if.slave bus_io,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [WIDTH-1:0]     lane_err_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic                 underflow_o,
  output logic                 timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TimeoutCnt = TW'(TIMEOUT);
  localparam logic [WIDTH-1:0] InvMask    = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] lane_err_q, lane_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             underflow_q, underflow_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;

  logic             empty, full, active, clear, push, pop;
  logic [WIDTH-1:0] head, mism;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign active = (state_q == StRun) || (state_q == StDrain);
  // start is honoured everywhere except DRAIN; a clearing cycle discards any push/pop.
  assign clear  = start_i && (state_q != StDrain);

  assign bus_io.stim_ready = (state_q == StRun) && !full;

  assign push = bus_io.stim_valid && bus_io.stim_ready && !clear;
  assign pop  = active && bus_io.resp_valid && !empty && !clear;
  assign head = mem_q[rptr_q[AW-1:0]];
  assign mism = head ^ bus_io.resp_data;

  // Next-state for FSM, FIFO pointers, drain counter and statistics.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    drain_cnt_d = drain_cnt_q;
    lane_err_d  = lane_err_q;
    err_count_d = err_count_q;
    underflow_d = underflow_q;
    timeout_d   = timeout_q;

    if (clear) begin
      state_d     = StRun;
      wptr_d      = '0;
      rptr_d      = '0;
      drain_cnt_d = '0;
      lane_err_d  = '0;
      err_count_d = '0;
      underflow_d = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rptr_d     = rptr_q + (AW + 1)'(1);
        lane_err_d = lane_err_q | mism;
        if ((mism != '0) && (err_count_q != {CNT_W{1'b1}})) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
      end
      // Emptiness is judged at the start of the cycle, so a same-cycle push does not help.
      if (active && bus_io.resp_valid && empty) begin
        underflow_d = 1'b1;
      end

      case (state_q)
        StRun: begin
          if (stop_i) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
        StDrain: begin
          if (empty) begin
            state_d = StDone;
          end else if (pop) begin
            drain_cnt_d = '0;
          end else if (drain_cnt_q + TW'(1) == TimeoutCnt) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end

    pass_d = (state_d == StDone) && (err_count_d == '0) && !underflow_d && !timeout_d;
  end

  // Control and statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      drain_cnt_q <= '0;
      lane_err_q  <= '0;
      err_count_q <= '0;
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      drain_cnt_q <= drain_cnt_d;
      lane_err_q  <= lane_err_d;
      err_count_q <= err_count_d;
      underflow_q <= underflow_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  // Expected-value storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= bus_io.stim_data ^ InvMask;
    end
  end

  assign busy_o      = active;
  assign done_o      = (state_q == StDone);
  assign pass_o      = pass_q;
  assign lane_err_o  = lane_err_q;
  assign err_count_o = err_count_q;
  assign underflow_o = underflow_q;
  assign timeout_o   = timeout_q;

endmodule
